// File: rtl/sdft_bin_rotator.sv
// rtl/sdft_bin_rotator.sv - sliding-DFT bin update X' = (X + delta)*W, 5-stage pipeline, plus sample-to-voltage scaler.
// Optional build macro SDFT_SAT_EN: saturating narrowing on bin and voltage results (default wraps).
module sdft_bin_rotator #(
    parameter int DATA_W     = 24,
    parameter int TW_FRAC    = 22,
    parameter int VOLT_GAIN  = 330,
    parameter int VOLT_SHIFT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_bin_real,
    input  logic [DATA_W-1:0] i_bin_imag,
    input  logic [DATA_W-1:0] i_delta,
    input  logic [DATA_W-1:0] i_twid_real,
    input  logic [DATA_W-1:0] i_twid_imag,
    output logic [DATA_W-1:0] o_out_real,
    output logic [DATA_W-1:0] o_out_imag,
    output logic              o_done,
    output logic              o_busy,
    input  logic              i_volt_start,
    input  logic [DATA_W-1:0] i_sample,
    output logic [DATA_W-1:0] o_voltage
);
    localparam int SW = DATA_W + 1;
    localparam int PW = 2 * DATA_W + 1;
    localparam int AW = 2 * DATA_W + 2;
    localparam int VW = DATA_W + 32;
    localparam int NW = (AW > VW) ? AW : VW;

    localparam logic signed [VW-1:0] VGAIN = VW'(VOLT_GAIN);

    function automatic logic [DATA_W-1:0] narrow(input logic signed [NW-1:0] v);
`ifdef SDFT_SAT_EN
        logic signed [NW-1:0] max_v;
        logic signed [NW-1:0] min_v;
        max_v = {{(NW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        min_v = {{(NW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        if (v > max_v)
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v < min_v)
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return v[DATA_W-1:0];
`else
        return v[DATA_W-1:0];
`endif
    endfunction

    logic signed [DATA_W-1:0] r_br, r_bi, r_dl, r_tr, r_ti;
    logic signed [SW-1:0]     r_s;
    logic signed [DATA_W-1:0] r_bi2, r_tr2, r_ti2;
    logic signed [PW-1:0]     r_p_str, r_p_sti, r_p_btr, r_p_bti;
    logic signed [AW-1:0]     r_re, r_im;
    logic                     r_v1, r_v2, r_v3, r_v4;
    logic                     r_done, r_busy;
    logic [DATA_W-1:0]        r_out_real, r_out_imag, r_voltage;

    logic                     w_accept;
    logic signed [SW-1:0]     w_s;
    logic signed [NW-1:0]     w_re_sh, w_im_sh;
    logic signed [VW-1:0]     w_vprod;
    logic signed [NW-1:0]     w_vsh;

    assign w_accept = i_start & ~r_busy;
    assign w_s      = SW'(r_br) + SW'(r_dl);
    // Arithmetic shift floors toward -infinity, matching the fixed-point twiddle scaling.
    assign w_re_sh  = NW'(r_re) >>> TW_FRAC;
    assign w_im_sh  = NW'(r_im) >>> TW_FRAC;
    assign w_vprod  = VW'($signed(i_sample)) * VGAIN;
    assign w_vsh    = NW'(w_vprod) >>> VOLT_SHIFT;

    // Datapath registers carry no reset; only the valid chain qualifies them.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_br <= i_bin_real;
            r_bi <= i_bin_imag;
            r_dl <= i_delta;
            r_tr <= i_twid_real;
            r_ti <= i_twid_imag;
        end
        r_s     <= w_s;
        r_bi2   <= r_bi;
        r_tr2   <= r_tr;
        r_ti2   <= r_ti;
        r_p_str <= PW'(r_s) * PW'(r_tr2);
        r_p_sti <= PW'(r_s) * PW'(r_ti2);
        r_p_btr <= PW'(r_bi2) * PW'(r_tr2);
        r_p_bti <= PW'(r_bi2) * PW'(r_ti2);
        r_re    <= AW'(r_p_str) - AW'(r_p_bti);
        r_im    <= AW'(r_p_sti) + AW'(r_p_btr);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_v4       <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_out_real <= '0;
            r_out_imag <= '0;
        end else begin
            r_v1   <= w_accept;
            r_v2   <= r_v1;
            r_v3   <= r_v2;
            r_v4   <= r_v3;
            r_done <= r_v4;
            if (w_accept)
                r_busy <= 1'b1;
            else if (r_done)
                r_busy <= 1'b0;
            if (r_v4) begin
                r_out_real <= narrow(w_re_sh);
                r_out_imag <= narrow(w_im_sh);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_voltage <= '0;
        else if (i_volt_start)
            r_voltage <= narrow(w_vsh);
    end

    assign o_out_real = r_out_real;
    assign o_out_imag = r_out_imag;
    assign o_done     = r_done;
    assign o_busy     = r_busy;
    assign o_voltage  = r_voltage;
endmodule

// File: tb/tb_sdft_bin_rotator.sv
// tb/tb_sdft_bin_rotator.sv - randomized self-checking bench for sdft_bin_rotator against an arithmetic model.
module tb_sdft_bin_rotator;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] bin_real, bin_imag, delta, twid_real, twid_imag;
    logic [23:0] out_real, out_imag;
    logic        done, busy;
    logic        volt_start;
    logic [23:0] sample, voltage;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sdft_bin_rotator dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_bin_real(bin_real), .i_bin_imag(bin_imag), .i_delta(delta),
        .i_twid_real(twid_real), .i_twid_imag(twid_imag),
        .o_out_real(out_real), .o_out_imag(out_imag),
        .o_done(done), .o_busy(busy),
        .i_volt_start(volt_start), .i_sample(sample), .o_voltage(voltage)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [23:0] x);
        return longint'($signed(x));
    endfunction

    function automatic logic [23:0] narrow_m(input longint v);
`ifdef SDFT_SAT_EN
        if (v > 64'sd8388607)  return 24'h7FFFFF;
        if (v < -64'sd8388608) return 24'h800000;
`endif
        return v[23:0];
    endfunction

    task automatic model(input logic [23:0] br, bi, dl, tr, ti,
                         output logic [23:0] er, ei);
        longint s, re, im;
        s  = sx(br) + sx(dl);
        re = s * sx(tr) - sx(bi) * sx(ti);
        im = s * sx(ti) + sx(bi) * sx(tr);
        er = narrow_m(re >>> 22);
        ei = narrow_m(im >>> 22);
    endtask

    function automatic logic [23:0] volt_m(input logic [23:0] smp);
        return narrow_m((sx(smp) * 330) >>> 15);
    endfunction

    task automatic set_ops(input logic [23:0] br, bi, dl, tr, ti);
        bin_real = br; bin_imag = bi; delta = dl; twid_real = tr; twid_imag = ti;
    endtask

    // One bin request with exact-latency checks; a voltage request rides on the same edge.
    task automatic run_op(input string tag, input logic [23:0] br, bi, dl, tr, ti,
                          input logic [23:0] er, ei);
        logic [23:0] smp;
        smp = 24'($urandom);
        @(negedge clk);
        set_ops(br, bi, dl, tr, ti);
        start = 1'b1; volt_start = 1'b1; sample = smp;
        @(posedge clk); #1;
        start = 1'b0; volt_start = 1'b0;
        set_ops(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
        sample = 24'($urandom);
        check({tag, " busy@1"}, 64'(busy), 64'd1);
        check({tag, " volt"}, 64'(voltage), 64'(volt_m(smp)));
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("%s done@%0d", tag, k), 64'(done), 64'(k == 4));
            check($sformatf("%s busy@%0d", tag, k), 64'(busy), 64'd1);
        end
        check({tag, " re"}, 64'(out_real), 64'(er));
        check({tag, " im"}, 64'(out_imag), 64'(ei));
        check({tag, " volt hold"}, 64'(voltage), 64'(volt_m(smp)));
        @(posedge clk); #1;
        check({tag, " done drop"}, 64'(done), 64'd0);
        check({tag, " busy drop"}, 64'(busy), 64'd0);
        check({tag, " re hold"}, 64'(out_real), 64'(er));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] br, bi, dl, tr, ti, er, ei, gr, gi;
        int dones;
        rst = 1'b1; start = 1'b0; volt_start = 1'b0; sample = '0;
        set_ops('0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst out_real", 64'(out_real), 64'd0);
        check("rst out_imag", 64'(out_imag), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst voltage", 64'(voltage), 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op("identity", 24'd100, 24'd50, 24'd10, 24'h400000, 24'h0, 24'd110, 24'd50);
        run_op("quarter", 24'd100, 24'd50, 24'd10, 24'h0, 24'h400000, -24'sd50, 24'd110);
        run_op("negquarter", 24'd100, 24'd50, 24'd10, 24'h0, 24'hC00000, 24'd50, -24'sd110);
`ifdef SDFT_SAT_EN
        run_op("ovf pos", 24'h7FFFFF, 24'h0, 24'h7FFFFF, 24'h400000, 24'h0, 24'h7FFFFF, 24'h0);
        run_op("ovf neg", 24'h800000, 24'h0, 24'h800000, 24'h400000, 24'h0, 24'h800000, 24'h0);
`else
        run_op("ovf pos", 24'h7FFFFF, 24'h0, 24'h7FFFFF, 24'h400000, 24'h0, 24'hFFFFFE, 24'h0);
        run_op("ovf neg", 24'h800000, 24'h0, 24'h800000, 24'h400000, 24'h0, 24'h000000, 24'h0);
`endif

        // Busy rejection: extra starts at edge T+2 and on the done cycle must be ignored.
        model(24'd1234, -24'sd777, 24'd99, 24'h2D413C, 24'hD2BEC4, er, ei);
        dones = 0; gr = '0; gi = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            start = (k == 0 || k == 2 || k == 5);
            if (k == 0) set_ops(24'd1234, -24'sd777, 24'd99, 24'h2D413C, 24'hD2BEC4);
            else        set_ops(24'd5555, 24'd4444, 24'd3333, 24'h400000, 24'h100000);
            @(posedge clk); #1;
            if (done) begin dones++; gr = out_real; gi = out_imag; end
        end
        start = 1'b0;
        check("busy rej dones", 64'(dones), 64'd1);
        check("busy rej re", 64'(gr), 64'(er));
        check("busy rej im", 64'(gi), 64'(ei));
        model(24'd7, 24'd8, 24'd9, 24'h200000, 24'h200000, er, ei);
        run_op("after done", 24'd7, 24'd8, 24'd9, 24'h200000, 24'h200000, er, ei);

        // Reset two cycles after start aborts the request.
        @(negedge clk);
        set_ops(24'd300, 24'd200, 24'd100, 24'h400000, 24'h0); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("midrst dones", 64'(dones), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst re", 64'(out_real), 64'd0);
        check("midrst im", 64'(out_imag), 64'd0);
        run_op("post rst", 24'd300, 24'd200, 24'd100, 24'h400000, 24'h0, 24'd400, 24'd200);

        // Voltage directed points and hold.
        @(negedge clk); volt_start = 1'b1; sample = 24'h008000;
        @(posedge clk); #1; volt_start = 1'b0; sample = 24'h123456;
        check("volt pos", 64'(voltage), 64'h00014A);
        @(negedge clk); volt_start = 1'b1; sample = 24'hFF8000;
        @(posedge clk); #1; volt_start = 1'b0; sample = 24'h7FFFFF;
        check("volt neg", 64'(voltage), 64'hFFFEB6);
        repeat (3) @(posedge clk);
        #1;
        check("volt hold", 64'(voltage), 64'hFFFEB6);
        @(negedge clk); volt_start = 1'b1; sample = 24'h7FFFFF;
        @(posedge clk); #1; volt_start = 1'b0;
        check("volt max", 64'(voltage), 64'(volt_m(24'h7FFFFF)));

        // Randomized requests across full-range and near-unit twiddles.
        for (int i = 0; i < 40; i++) begin
            br = 24'($urandom); bi = 24'($urandom); dl = 24'($urandom);
            if (i % 2 == 0) begin
                tr = 24'($signed(24'($urandom_range(0, 24'h800000))) - 24'sh400000);
                ti = 24'($signed(24'($urandom_range(0, 24'h800000))) - 24'sh400000);
            end else begin
                tr = 24'($urandom); ti = 24'($urandom);
            end
            model(br, bi, dl, tr, ti, er, ei);
            run_op($sformatf("rand%0d", i), br, bi, dl, tr, ti, er, ei);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sdft_bin_rotator.md
Name: sdft_bin_rotator

Overview:
Arithmetic core of the sliding-DFT engine. Per frequency bin it takes the stored complex bin value, the sample delta (newest minus oldest sample) and one complex twiddle factor, and returns the updated bin X' = (X + delta)·W, with real and imaginary parts computed in parallel. A side channel converts the current sample code into a scaled voltage reading for the display/output path. The FFT control FSM drives one request per bin and waits for the done pulse.

Parameters:
DATA_W, 24, width of bin, delta, twiddle, sample and result words (two's complement)
TW_FRAC, 22, fractional bits of twiddle words (1.0 = 2^TW_FRAC)
VOLT_GAIN, 330, unsigned voltage scale multiplier
VOLT_SHIFT, 15, arithmetic right shift applied after VOLT_GAIN multiply

Ports:
clk  in  1  single system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request pulse; operands sampled on this edge
bin_real  in  DATA_W  current bin real part
bin_imag  in  DATA_W  current bin imaginary part
delta  in  DATA_W  newest minus oldest sample
twid_real  in  DATA_W  twiddle cosine term, Q(DATA_W-TW_FRAC).TW_FRAC
twid_imag  in  DATA_W  twiddle sine term, same format
out_real  out  DATA_W  updated bin real part
out_imag  out  DATA_W  updated bin imaginary part
done  out  1  one-cycle pulse when out_real/out_imag are valid
busy  out  1  high from accepted start until done inclusive
volt_start  in  1  voltage-conversion request pulse
sample  in  DATA_W  signed sample code for conversion
voltage  out  DATA_W  scaled voltage

Behaviour:
- Reset: out_real, out_imag, voltage = 0; done = 0; busy = 0; pipeline valid bits cleared. Reset mid-operation aborts the operation; no done pulse follows.
- Handshake: start is accepted only when busy = 0. A start while busy = 1 is ignored, with no effect on the pipeline or operands. A new start on the same cycle done pulses is ignored (busy is still high).
- Latency: start accepted at edge T; busy = 1 from T+1; done = 1 for exactly the cycle following edge T+4; busy drops with done.
- Stage 1 (edge T): register all five operands.
- Stage 2: s = bin_real + delta, sign-extended to DATA_W+1 bits (no overflow).
- Stage 3: four signed products: s·twid_real, s·twid_imag, bin_imag·twid_real, bin_imag·twid_imag (each 2·DATA_W+1 bits).
- Stage 4: re = s·tr − bi·ti; im = s·ti + bi·tr (2·DATA_W+2 bits).
- Scaling: arithmetic right shift by TW_FRAC, which floors toward −infinity.
- Narrowing: result reduced to DATA_W bits, either wrapped or saturated (see Optional Feature). Registered into out_real/out_imag on the edge that raises done.
- Outputs hold their value until the next done.
- Voltage path, independent of the bin pipeline: on volt_start, voltage <= (sample × VOLT_GAIN) >>> VOLT_SHIFT, truncated to DATA_W bits. It is valid one cycle after volt_start and held otherwise. volt_start and start may coincide without interaction.
- No state persists between bin requests; the caller owns bin storage.

Optional Feature:
SDFT_SAT_EN.
- Defined: the stage-4 narrowing saturates. Values above 2^(DATA_W−1)−1 clamp to 0x7FFFFF; values below −2^(DATA_W−1) clamp to 0x800000. The voltage result saturates the same way.
- Undefined: both paths keep the low DATA_W bits (two's-complement wrap).
- Latency is identical in both builds.

Test Plan:
- Identity twiddle: tr=0x400000, ti=0, bin=(100,50), delta=10, pulse start -> done exactly 4 cycles later, out=(110,50), busy high for 4 cycles.
- Quarter-turn twiddle: tr=0, ti=0x400000, bin=(100,50), delta=10 -> out=(−50,110); then tr=0, ti=0xC00000 (−1.0) -> out=(50,−110).
- Overflow: bin_real=0x7FFFFF, delta=0x7FFFFF, tr=1.0, ti=0, bin_imag=0 -> with SDFT_SAT_EN out_real=0x7FFFFF; without it out_real=0xFFFFFE.
- Busy rejection: second start 2 cycles after first, with different operands -> single done, results from first operands; start after done is accepted normally.
- Reset mid-op: assert rst 2 cycles after start -> no done, outputs 0; fresh start afterwards completes correctly.
- Voltage: sample=0x008000 with volt_start -> voltage=330 next cycle; sample=0xFF8000 -> voltage=−330 (0xFFFEB6); voltage holds when volt_start is low.
